// File: rtl/fifo_stream_buffer.sv
// First-word-fall-through stream FIFO with valid/ready ports on both sides.
// Optional occupancy outputs (level, almost_full) are enabled by defining FIFO_LEVEL_EN.
module fifo_stream_buffer #(
  parameter int num_bits          = 16,
  parameter int depth             = 16,
  parameter int almost_full_level = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [num_bits-1:0]     in_data,
  input  logic                    in_enable,
  output logic                    in_ready,
  output logic [num_bits-1:0]     out_data,
  output logic                    out_enable,
  input  logic                    out_ready
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(depth):0]  level,
  output logic                    almost_full
`endif
);

  localparam int AW = $clog2(depth);

  if ((depth < 2) || ((depth & (depth - 1)) != 0) || (almost_full_level > depth)) begin : g_bad_params
    $error("fifo_stream_buffer: depth must be a power of two >= 2 and almost_full_level <= depth");
  end

  logic [num_bits-1:0] mem_q [depth];
  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         wr_ptr_d;
  logic [AW:0]         rd_ptr_q;
  logic [AW:0]         rd_ptr_d;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;

  // Status flags, transfer qualifiers and pointer next-state; flags depend on registered pointers only.
  always_comb begin
    empty_s  = (wr_ptr_q == rd_ptr_q);
    full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push_s   = in_enable && !full_s;
    pop_s    = out_ready && !empty_s;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; the wrap bit falls out of the natural AW+1-bit rollover.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // Output port drive; the head word is forced to zero while empty.
  always_comb begin
    in_ready   = !full_s;
    out_enable = !empty_s;
    if (empty_s) begin
      out_data = {num_bits{1'b0}};
    end else begin
      out_data = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

`ifdef FIFO_LEVEL_EN
  // Occupancy from the modulo pointer difference.
  always_comb begin
    level       = wr_ptr_q - rd_ptr_q;
    almost_full = (level >= (AW+1)'(almost_full_level));
  end
`endif

endmodule

// File: tb/tb_fifo_stream_buffer.sv
// Self-checking bench for fifo_stream_buffer: a directed vector table plus
// queue-model sequences for fill/drain, wrap, simultaneous and reset corners.
module tb_fifo_stream_buffer;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_enable;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_enable;
  logic        out_ready;
`ifdef FIFO_LEVEL_EN
  logic [4:0]  level;
  logic        almost_full;
`endif

  int n_vec;
  int n_bad;
  logic [15:0] model_q[$];

  fifo_stream_buffer #(.num_bits(16), .depth(16), .almost_full_level(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_enable  (in_enable),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_enable (out_enable),
    .out_ready  (out_ready)
`ifdef FIFO_LEVEL_EN
    ,
    .level      (level),
    .almost_full(almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ie;
    logic [15:0] d;
    logic        rdy;
    logic        exp_ir;
    logic        exp_oe;
    logic [15:0] exp_od;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle against the queue model: drive, check pre-edge state, then advance the model.
  task automatic cyc(input logic ie, input logic [15:0] d, input logic rdy);
    logic do_push;
    logic do_pop;
    int   sz;
    @(negedge clk);
    in_enable = ie;
    in_data   = d;
    out_ready = rdy;
    #1;
    sz = model_q.size();
    chk("in_ready", {31'd0, in_ready}, {31'd0, (sz < 16)});
    chk("out_enable", {31'd0, out_enable}, {31'd0, (sz != 0)});
    chk("out_data", {16'd0, out_data}, {16'd0, (sz != 0) ? model_q[0] : 16'h0000});
`ifdef FIFO_LEVEL_EN
    chk("level", {27'd0, level}, sz);
    chk("almost_full", {31'd0, almost_full}, {31'd0, (sz >= 12)});
`endif
    do_push = ie && (sz < 16);
    do_pop  = rdy && (sz != 0);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_enable"}, {31'd0, out_enable}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
`ifdef FIFO_LEVEL_EN
    chk({tag, "_level"}, {27'd0, level}, 32'd0);
    chk({tag, "_almost_full"}, {31'd0, almost_full}, 32'd0);
`endif
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    in_enable = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    // single word, pop pulse, empty-boundary simultaneous push/pop
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1234};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 16'hAAAA};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h5555};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h5555};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_enable = vecs[i].ie;
      in_data   = vecs[i].d;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_out_enable", i), {31'd0, out_enable}, {31'd0, vecs[i].exp_oe});
      chk($sformatf("vec%0d_out_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp_od});
    end

    // fill to 16, hold a 17th word, then pop-only while full
    for (int k = 0; k < 16; k++) cyc(1'b1, 16'(k), 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1);
    @(negedge clk);
    in_enable = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
    chk("full_pop_head", {16'd0, out_data}, 32'h0001);
    for (int k = 0; k < 16; k++) cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);

    // 40 streamed words to wrap the pointers, then drain
    for (int k = 0; k < 40; k++) cyc(1'b1, 16'(16'h0100 + k), 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 16'h0000, 1'b1);

    // steady-state at level 8
    for (int k = 0; k < 8; k++) cyc(1'b1, 16'(16'h0200 + k), 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 16'(16'h0300 + k), 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("mid_level_occupancy", model_q.size(), 32'd8);
    for (int k = 0; k < 9; k++) cyc(1'b0, 16'h0000, 1'b1);

    // asynchronous reset with 5 words stored
    for (int k = 0; k < 5; k++) cyc(1'b1, 16'(16'h0400 + k), 1'b0);
    in_enable = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b0);

    // random stress
    for (int k = 0; k < 1000; k++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 17; k++) cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
